// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch stage state encoding, opcode constants and NOP word
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLEZ = 6'h06;
    localparam logic [5:0] OP_BGTZ = 6'h07;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ);
    endfunction

endpackage

// File: rtl/fetch_predict.sv
// rtl/fetch_predict.sv - static BTFN predictor: jumps and backward branches taken
module fetch_predict
    import fetch_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;

    assign pc_plus4      = pc + 32'd4;
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = pc_plus4;
        if (instr[31:26] == OP_J) begin
            taken  = 1'b1;
            target = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (is_cond_branch(instr[31:26]) && instr[15]) begin
            taken  = 1'b1;
            target = pc_plus4 + branch_offset;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding the IF/ID register
// Optional static prediction enabled by defining FETCH_PREDICT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [31:0] Redirect_Addr_IN,
    output logic        Imem_Req_OUT,
    output logic [31:0] Imem_Addr_OUT,
    input  logic        Imem_Valid_IN,
    input  logic [31:0] Imem_Data_IN,
    output logic [31:0] Instr1_IF,
    output logic [31:0] Instr_PC_IF,
    output logic [31:0] Instr_PC_Plus4_IF,
    output logic        Instr_Valid_IF,
    output logic        Pred_Taken_IF
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    logic         pred_taken;
    logic [31:0]  pred_target;

    assign pc_plus4 = pc + 32'd4;

`ifdef FETCH_PREDICT_EN
    fetch_predict u_predict (
        .instr  (Imem_Data_IN),
        .pc     (pc),
        .taken  (pred_taken),
        .target (pred_target)
    );
`else
    assign pred_taken  = 1'b0;
    assign pred_target = pc_plus4;
`endif

    assign next_pc = pred_taken ? pred_target : pc_plus4;

    // Request is a pure decode of state so it drops the instant reset asserts.
    assign Imem_Req_OUT  = (state == ST_ISSUE) && RESET;
    assign Imem_Addr_OUT = pc;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state             <= ST_ISSUE;
            pc                <= RESET_VECTOR;
            Instr1_IF         <= NOP_WORD;
            Instr_PC_IF       <= 32'd0;
            Instr_PC_Plus4_IF <= 32'd0;
            Instr_Valid_IF    <= 1'b0;
            Pred_Taken_IF     <= 1'b0;
        end else begin
            case (state)
                ST_ISSUE: begin
                    // The request already went out this cycle, so a flush must wait out its response.
                    if (FLUSH) begin
                        pc    <= Redirect_Addr_IN;
                        state <= ST_DROP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (FLUSH) begin
                        pc                <= Redirect_Addr_IN;
                        Instr1_IF         <= NOP_WORD;
                        Instr_PC_IF       <= 32'd0;
                        Instr_PC_Plus4_IF <= 32'd0;
                        Instr_Valid_IF    <= 1'b0;
                        Pred_Taken_IF     <= 1'b0;
                        state             <= Imem_Valid_IN ? ST_ISSUE : ST_DROP;
                    end else if (Imem_Valid_IN) begin
                        Instr1_IF         <= Imem_Data_IN;
                        Instr_PC_IF       <= pc;
                        Instr_PC_Plus4_IF <= pc_plus4;
                        Instr_Valid_IF    <= 1'b1;
                        Pred_Taken_IF     <= pred_taken;
                        pc                <= next_pc;
                        state             <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (FLUSH || !STALL) begin
                        if (FLUSH) begin
                            pc <= Redirect_Addr_IN;
                        end
                        Instr1_IF         <= NOP_WORD;
                        Instr_PC_IF       <= 32'd0;
                        Instr_PC_Plus4_IF <= 32'd0;
                        Instr_Valid_IF    <= 1'b0;
                        Pred_Taken_IF     <= 1'b0;
                        state             <= ST_ISSUE;
                    end
                end
                ST_DROP: begin
                    if (FLUSH) begin
                        pc <= Redirect_Addr_IN;
                    end
                    if (Imem_Valid_IN) begin
                        state <= ST_ISSUE;
                    end
                end
                default: state <= ST_ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (honours FETCH_PREDICT_EN)
module tb_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] Redirect_Addr_IN;
    logic        Imem_Req_OUT;
    logic [31:0] Imem_Addr_OUT;
    logic        Imem_Valid_IN;
    logic [31:0] Imem_Data_IN;
    logic [31:0] Instr1_IF;
    logic [31:0] Instr_PC_IF;
    logic [31:0] Instr_PC_Plus4_IF;
    logic        Instr_Valid_IF;
    logic        Pred_Taken_IF;

    logic        auto_mem;
    logic        auto_valid;
    logic [31:0] auto_data;
    logic        man_valid;
    logic [31:0] man_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] req_q[$];
    logic [96:0] slot_q[$];

`ifdef FETCH_PREDICT_EN
    localparam logic        BNE_PRED = 1'b1;
    localparam logic [31:0] BNE_NEXT = 32'h0040_0004;
`else
    localparam logic        BNE_PRED = 1'b0;
    localparam logic [31:0] BNE_NEXT = 32'h0040_0014;
`endif

    assign Imem_Valid_IN = auto_mem ? auto_valid : man_valid;
    assign Imem_Data_IN  = auto_mem ? auto_data  : man_data;

    fetch_unit #(.RESET_VECTOR(32'hBFC0_0000)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .FLUSH             (FLUSH),
        .Redirect_Addr_IN  (Redirect_Addr_IN),
        .Imem_Req_OUT      (Imem_Req_OUT),
        .Imem_Addr_OUT     (Imem_Addr_OUT),
        .Imem_Valid_IN     (Imem_Valid_IN),
        .Imem_Data_IN      (Imem_Data_IN),
        .Instr1_IF         (Instr1_IF),
        .Instr_PC_IF       (Instr_PC_IF),
        .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF),
        .Instr_Valid_IF    (Instr_Valid_IF),
        .Pred_Taken_IF     (Pred_Taken_IF)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!Instr_Valid_IF && n < 20) begin
            step();
            n++;
        end
        check("slot_arrival", {127'd0, Instr_Valid_IF}, 128'd1);
    endtask

    // Auto memory: answers the request one cycle later with the inverted address as data.
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        pend       = 1'b0;
        pend_addr  = 32'd0;
        auto_valid = 1'b0;
        auto_data  = 32'd0;
        forever begin
            @(negedge CLK);
            if (auto_mem && Imem_Req_OUT) begin
                pend      = 1'b1;
                pend_addr = Imem_Addr_OUT;
            end
            @(posedge CLK);
            #2;
            auto_valid = 1'b0;
            if (pend) begin
                auto_valid = 1'b1;
                auto_data  = ~pend_addr;
                pend       = 1'b0;
            end
        end
    end

    // Monitor: every request and every consumed slot is matched against the scoreboard.
    always @(negedge CLK) begin
        if (Imem_Req_OUT) begin
            if (req_q.size() == 0) check("unexpected_req", {96'd0, Imem_Addr_OUT}, 128'd0);
            else check("req_addr", {96'd0, Imem_Addr_OUT}, {96'd0, req_q.pop_front()});
        end
        if (Instr_Valid_IF && !STALL && !FLUSH) begin
            if (slot_q.size() == 0) check("unexpected_slot", {127'd0, Instr_Valid_IF}, 128'd0);
            else check("slot_contents",
                       {31'd0, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF, Pred_Taken_IF},
                       {31'd0, slot_q.pop_front()});
        end
    end

    initial begin
        RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0; Redirect_Addr_IN = 32'd0;
        man_valid = 1'b0; man_data = 32'd0; auto_mem = 1'b1;

        // Reset state
        step(); step();
        check("rst_req",   {127'd0, Imem_Req_OUT}, 128'd0);
        check("rst_addr",  {96'd0, Imem_Addr_OUT}, {96'd0, 32'hBFC0_0000});
        check("rst_instr", {96'd0, Instr1_IF}, 128'd0);
        check("rst_pc",    {96'd0, Instr_PC_IF}, 128'd0);
        check("rst_pc4",   {96'd0, Instr_PC_Plus4_IF}, 128'd0);
        check("rst_valid", {126'd0, Instr_Valid_IF, Pred_Taken_IF}, 128'd0);

        // Sequential fetch with a 1-cycle memory
        for (int i = 0; i < 4; i++) req_q.push_back(32'hBFC0_0000 + 32'(4 * i));
        slot_q.push_back({32'h403F_FFFF, 32'hBFC0_0000, 32'hBFC0_0004, 1'b0});
        slot_q.push_back({32'h403F_FFFB, 32'hBFC0_0004, 32'hBFC0_0008, 1'b0});
        slot_q.push_back({32'h403F_FFF7, 32'hBFC0_0008, 32'hBFC0_000C, 1'b0});
        RESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid();
            if (k < 2) step();
        end

        // Stall with a full slot: everything frozen, no new request
        STALL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_instr", {96'd0, Instr1_IF}, {96'd0, 32'h403F_FFF7});
            check("stall_pc",    {96'd0, Instr_PC_IF}, {96'd0, 32'hBFC0_0008});
            check("stall_pc4",   {96'd0, Instr_PC_Plus4_IF}, {96'd0, 32'hBFC0_000C});
            check("stall_flags", {126'd0, Instr_Valid_IF, Imem_Req_OUT}, 128'd2);
        end
        STALL = 1'b0;
        auto_mem = 1'b0;

        // Flush during WAIT, stale response three cycles later
        step();
        step();
        FLUSH = 1'b1; Redirect_Addr_IN = 32'h0040_0020;
        step();
        FLUSH = 1'b0;
        check("drop_valid0", {127'd0, Instr_Valid_IF}, 128'd0);
        step();
        check("drop_valid1", {126'd0, Instr_Valid_IF, Imem_Req_OUT}, 128'd0);
        step();
        man_valid = 1'b1; man_data = 32'hDEAD_BEEF;
        req_q.push_back(32'h0040_0020);
        step();
        man_valid = 1'b0;
        check("stale_discarded", {127'd0, Instr_Valid_IF}, 128'd0);
        check("redirect_addr",   {96'd0, Imem_Addr_OUT}, {96'd0, 32'h0040_0020});

        // Flush, response and stall in the same WAIT cycle
        step();
        FLUSH = 1'b1; STALL = 1'b1; man_valid = 1'b1; man_data = 32'h1234_5678;
        Redirect_Addr_IN = 32'h0040_0010;
        req_q.push_back(32'h0040_0010);
        step();
        FLUSH = 1'b0; STALL = 1'b0; man_valid = 1'b0;
        check("flush_valid_slot",  {96'd0, Instr1_IF}, 128'd0);
        check("flush_valid_state", {126'd0, Instr_Valid_IF, Imem_Req_OUT}, 128'd1);

        // Backward BNE at 00400010
        step();
        man_valid = 1'b1; man_data = 32'h1422_FFFC;
        slot_q.push_back({32'h1422_FFFC, 32'h0040_0010, 32'h0040_0014, BNE_PRED});
        req_q.push_back(BNE_NEXT);
        step();
        man_valid = 1'b0;
        check("bne_pred", {127'd0, Pred_Taken_IF}, {127'd0, BNE_PRED});
        step();

        // Flush in ISSUE to the top of the address space, then wrap
        FLUSH = 1'b1; Redirect_Addr_IN = 32'hFFFF_FFFC;
        step();
        FLUSH = 1'b0; man_valid = 1'b1; man_data = 32'h0000_0000;
        step();
        man_valid = 1'b0;
        req_q.push_back(32'hFFFF_FFFC);
        slot_q.push_back({32'h2400_0001, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0});
        step();
        man_valid = 1'b1; man_data = 32'h2400_0001;
        step();
        man_valid = 1'b0;
        check("wrap_pc4", {96'd0, Instr_PC_Plus4_IF}, 128'd0);
        req_q.push_back(32'h0000_0000);
        step();
        step();

        // Reset in the middle of WAIT, late response ignored
        RESET = 1'b0;
        #1;
        check("midrst_req",   {127'd0, Imem_Req_OUT}, 128'd0);
        check("midrst_addr",  {96'd0, Imem_Addr_OUT}, {96'd0, 32'hBFC0_0000});
        check("midrst_slot",  {31'd0, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF, Pred_Taken_IF}, 128'd0);
        check("midrst_valid", {127'd0, Instr_Valid_IF}, 128'd0);
        man_valid = 1'b1; man_data = 32'hCAFE_F00D;
        step();
        man_valid = 1'b0;
        step();
        RESET = 1'b1;
        req_q.push_back(32'hBFC0_0000);
        step();
        step();
        check("late_resp_ignored", {127'd0, Instr_Valid_IF}, 128'd0);

        @(negedge CLK);
        #1;
        check("req_queue_drained",  128'(req_q.size()), 128'd0);
        check("slot_queue_drained", 128'(slot_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
